vip_axi4_burst_addr_gen: RTL

- Consumes one AXI4 address-channel request (addr, len, size, burst) and expands it into a per-beat stream of address, byte strobe, index and last flag.
- Sits directly downstream of the AXI4 AW/AR capture logic in the slave-side memory model and bus monitors.
- Feeds the data-beat engines that read and write memory.
- Rejects illegal requests with a one-cycle error pulse instead of emitting beats.

---
 rtl/vip_axi4_burst_addr_gen.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/vip_axi4_burst_addr_gen.sv
// AXI4 address-channel burst expander: one request in, one address/strobe/index/last beat per transfer out.
// Optional VIP_AXI4_4K_CHECK_EN rejects INCR bursts that cross a 4 KB page.
module vip_axi4_burst_addr_gen #(
  parameter int ADDR_WIDTH_P = 32,
  parameter int DATA_WIDTH_P = 32,
  parameter int STRB_WIDTH_P = DATA_WIDTH_P / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH_P-1:0] cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  output logic                    cmd_err,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output logic [ADDR_WIDTH_P-1:0] beat_addr,
  output logic [STRB_WIDTH_P-1:0] beat_strb,
  output logic [7:0]              beat_idx,
  output logic                    beat_last,
  output logic                    busy
);

  localparam logic [ADDR_WIDTH_P-1:0] ONE       = ADDR_WIDTH_P'(1);
  localparam logic [ADDR_WIDTH_P-1:0] LANE_MASK = ADDR_WIDTH_P'(STRB_WIDTH_P - 1);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_ERR} state_t;

  state_t state, state_n;

  logic                    cmd_ready_n, cmd_err_n, beat_valid_n, beat_last_n, busy_n;
  logic [ADDR_WIDTH_P-1:0] beat_addr_n;
  logic [STRB_WIDTH_P-1:0] beat_strb_n;
  logic [7:0]              beat_idx_n;

  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [ADDR_WIDTH_P-1:0] wmask_q;

  logic                    accept, illegal;
  logic [ADDR_WIDTH_P-1:0] bytes_c, total_c, bytes_q, nxt_addr, sum_addr;

  // Lanes from the address offset up to the end of the size-aligned container.
  function automatic logic [STRB_WIDTH_P-1:0] lane_strb(input logic [ADDR_WIDTH_P-1:0] a,
                                                       input logic [2:0] sz);
    logic [ADDR_WIDTH_P-1:0] nbytes, lo, hi;
    lane_strb = '0;
    nbytes    = ONE << sz;
    lo        = a & LANE_MASK;
    hi        = ((a & ~(nbytes - ONE)) & LANE_MASK) + nbytes - ONE;
    for (int unsigned i = 0; i < STRB_WIDTH_P; i++)
      lane_strb[i] = (ADDR_WIDTH_P'(i) >= lo) && (ADDR_WIDTH_P'(i) <= hi);
  endfunction

  assign accept  = cmd_valid && cmd_ready;
  assign bytes_c = ONE << cmd_size;
  assign total_c = (ADDR_WIDTH_P'(cmd_len) + ONE) << cmd_size;
  assign bytes_q = ONE << size_q;

`ifdef VIP_AXI4_4K_CHECK_EN
  logic [ADDR_WIDTH_P-1:0] last_byte_c;
  logic                    cross_4k;
  assign last_byte_c = (cmd_addr & ~(bytes_c - ONE)) + total_c - ONE;
  assign cross_4k    = (cmd_burst == BURST_INCR) &&
                       (last_byte_c[ADDR_WIDTH_P-1:12] != cmd_addr[ADDR_WIDTH_P-1:12]);
`else
  logic cross_4k;
  assign cross_4k = 1'b0;
`endif

  always_comb begin
    illegal = 1'b0;
    if (cmd_burst == BURST_RSVD)
      illegal = 1'b1;
    if ((32'd1 << cmd_size) > 32'(STRB_WIDTH_P))
      illegal = 1'b1;
    if (cmd_burst == BURST_WRAP) begin
      if (!(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
        illegal = 1'b1;
      if ((cmd_addr & (bytes_c - ONE)) != '0)
        illegal = 1'b1;
    end
    if (cross_4k)
      illegal = 1'b1;
  end

  // WRAP start is size-aligned, so reaching a total-aligned address means we hit lower+total.
  always_comb begin
    sum_addr = beat_addr + bytes_q;
    nxt_addr = beat_addr;
    case (burst_q)
      BURST_INCR: nxt_addr = (beat_addr & ~(bytes_q - ONE)) + bytes_q;
      BURST_WRAP: nxt_addr = ((sum_addr & wmask_q) == '0) ? (beat_addr & ~wmask_q) : sum_addr;
      default:    nxt_addr = beat_addr;
    endcase
  end

  always_comb begin
    state_n      = state;
    cmd_ready_n  = cmd_ready;
    cmd_err_n    = 1'b0;
    beat_valid_n = beat_valid;
    beat_addr_n  = beat_addr;
    beat_strb_n  = beat_strb;
    beat_idx_n   = beat_idx;
    beat_last_n  = beat_last;
    busy_n       = busy;
    case (state)
      ST_IDLE: begin
        cmd_ready_n = 1'b1;
        if (accept) begin
          cmd_ready_n = 1'b0;
          if (illegal) begin
            cmd_err_n = 1'b1;
            state_n   = ST_ERR;
          end else begin
            state_n      = ST_BURST;
            busy_n       = 1'b1;
            beat_valid_n = 1'b1;
            beat_addr_n  = cmd_addr;
            beat_strb_n  = lane_strb(cmd_addr, cmd_size);
            beat_idx_n   = 8'd0;
            beat_last_n  = (cmd_len == 8'd0);
          end
        end
      end
      ST_ERR: begin
        cmd_ready_n = 1'b1;
        state_n     = ST_IDLE;
      end
      ST_BURST: begin
        if (beat_ready) begin
          if (beat_last) begin
            state_n      = ST_IDLE;
            beat_valid_n = 1'b0;
            busy_n       = 1'b0;
            cmd_ready_n  = 1'b1;
          end else begin
            beat_addr_n = nxt_addr;
            beat_strb_n = lane_strb(nxt_addr, size_q);
            beat_idx_n  = beat_idx + 8'd1;
            beat_last_n = ((beat_idx + 8'd1) == len_q);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b0;
      cmd_err    <= 1'b0;
      beat_valid <= 1'b0;
      beat_addr  <= '0;
      beat_strb  <= '0;
      beat_idx   <= '0;
      beat_last  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cmd_ready  <= cmd_ready_n;
      cmd_err    <= cmd_err_n;
      beat_valid <= beat_valid_n;
      beat_addr  <= beat_addr_n;
      beat_strb  <= beat_strb_n;
      beat_idx   <= beat_idx_n;
      beat_last  <= beat_last_n;
      busy       <= busy_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BURST_FIXED;
      wmask_q <= '0;
    end else if (accept) begin
      len_q   <= cmd_len;
      size_q  <= cmd_size;
      burst_q <= cmd_burst;
      wmask_q <= total_c - ONE;
    end
  end

endmodule
